// File: rtl/mul_pkg.sv
// Shared constants, FSM state type and defaults for the multiply sequencer.
package mul_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_CYCLES = 32;

    // Multiply-group function codes; OUT also acts as the multiplier's "hold" step code.
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] OUT   = 6'b111111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE
    } state_t;

    // Counter width for a 0..cycles-1 step count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Step counter for the RUN state: clears on LOAD, counts while enabled,
// flags the last step so the FSM can leave RUN.
module mul_step_counter
    import mul_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = cnt_width(CYCLES);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = (count_q == CW'(CYCLES - 1));

    // Next count: clear on request or when wrapping past the last step.
    always_comb begin
        count_d = count_q;
        if (clr_i || (en_i && tc_o)) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequencer and HI/LO result holder for the iterative unsigned multiplier.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned CYCLES = DEF_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         Signal,
    input  logic [2*WIDTH-1:0] mulProduct,
    output logic               mulLoad,
    output logic [5:0]         mulSignal,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataOut
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             mul_load_q, mul_load_d;
    logic [5:0]       mul_sig_q, mul_sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_tc;

    mul_step_counter #(
        .CYCLES(CYCLES)
    ) u_step_cnt (
        .clk_i (clk),
        .rst_ni(reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state, HI/LO/read-data updates and output decode.
    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and never glitch.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dout_d  = dout_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (Signal)
                        MULTU:   state_d = LOAD;
                        MFHI:    dout_d  = hi_q;
                        MFLO:    dout_d  = lo_q;
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                hi_d    = mulProduct[2*WIDTH-1:WIDTH];
                lo_d    = mulProduct[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mul_load_d = (state_d == LOAD);
        mul_sig_d  = (state_d == RUN) ? MULTU : OUT;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == CAPTURE);
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mul_load_q <= 1'b0;
            mul_sig_q  <= OUT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_load_q <= mul_load_d;
            mul_sig_q  <= mul_sig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // HI/LO result registers and the read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dout_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dout_q <= dout_d;
        end
    end

    assign mulLoad   = mul_load_q;
    assign mulSignal = mul_sig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dataOut   = dout_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a behavioural shift-add multiplier.
module tb_mul_hilo_ctrl;

    localparam int W = 32;
    localparam int C = 32;

    localparam logic [5:0] TB_MULTU = 6'b011001;
    localparam logic [5:0] TB_MFHI  = 6'b010000;
    localparam logic [5:0] TB_MFLO  = 6'b010010;
    localparam logic [5:0] TB_OUT   = 6'b111111;

    logic           clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           start  = 1'b0;
    logic [5:0]     Signal = 6'd0;
    logic [2*W-1:0] mulProduct;
    logic           mulLoad;
    logic [5:0]     mulSignal;
    logic           busy;
    logic           done;
    logic [W-1:0]   dataOut;

    logic [W-1:0]   dataA = '0;
    logic [W-1:0]   dataB = '0;
    logic [2*W-1:0] mreg  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference HI/LO contents, updated from plain arithmetic.
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    // Per-cycle trace of one multiply, index = cycles after the start edge.
    logic         tr_load [0:C+3];
    logic [5:0]   tr_sig  [0:C+3];
    logic         tr_busy [0:C+3];
    logic         tr_done [0:C+3];
    logic [W-1:0] tr_dout [0:C+3];

    mul_hilo_ctrl #(
        .WIDTH (W),
        .CYCLES(C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Signal    (Signal),
        .mulProduct(mulProduct),
        .mulLoad   (mulLoad),
        .mulSignal (mulSignal),
        .busy      (busy),
        .done      (done),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    // One shift-add step: add multiplicand into the upper half if the LSB is set, shift right.
    function automatic logic [2*W-1:0] mstep(input logic [2*W-1:0] p, input logic [W-1:0] a);
        logic [W:0] s;
        s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
        return {s, p[W-1:1]};
    endfunction

    // Stand-in for the existing multiplier: load on mulLoad, step on MULTU, hold on OUT.
    always @(posedge clk) begin
        if (mulLoad) begin
            mreg <= {{W{1'b0}}, dataB};
        end else if (mulSignal == TB_MULTU) begin
            mreg <= mstep(mreg, dataA);
        end
    end
    assign mulProduct = mreg;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a read and return dataOut one cycle later.
    task automatic read_reg(input logic [5:0] code, output logic [W-1:0] v);
        Signal = code;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        Signal = 6'd0;
        v      = dataOut;
    endtask

    // Issue MULTU, optionally pulse another request at cycle inj, record the trace,
    // and return in the first IDLE cycle (C+3).
    task automatic run_multu(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int inj, input logic [5:0] inj_code);
        logic [2*W-1:0] prod;
        dataA  = a;
        dataB  = b;
        Signal = TB_MULTU;
        start  = 1'b1;
        tick();
        for (int c = 1; c <= C + 3; c++) begin
            start      = (c == inj);
            Signal     = (c == inj) ? inj_code : 6'd0;
            tr_load[c] = mulLoad;
            tr_sig[c]  = mulSignal;
            tr_busy[c] = busy;
            tr_done[c] = done;
            tr_dout[c] = dataOut;
            if (c < C + 3) tick();
        end
        start  = 1'b0;
        Signal = 6'd0;
        prod   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        exp_hi = prod[2*W-1:W];
        exp_lo = prod[W-1:0];
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (mulLoad !== 1'b0) begin n_fail++; $display("FAIL reset_mulLoad: got %b want 0", mulLoad); end
        n_checks++; if (mulSignal !== TB_OUT) begin n_fail++; $display("FAIL reset_mulSignal: got %b want %b", mulSignal, TB_OUT); end
        n_checks++; if (dataOut !== '0) begin n_fail++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_simple_multiply;
        int ndone;
        logic [W-1:0] v;
        run_multu(32'd3, 32'd5, 0, 6'd0);
        ndone = 0;
        for (int c = 1; c <= C + 3; c++) begin
            n_checks++;
            if (tr_load[c] !== (c == 1)) begin
                n_fail++; $display("FAIL simple_mulLoad c=%0d: got %b want %b", c, tr_load[c], (c == 1));
            end
            n_checks++;
            if (tr_sig[c] !== ((c >= 2 && c <= C + 1) ? TB_MULTU : TB_OUT)) begin
                n_fail++; $display("FAIL simple_mulSignal c=%0d: got %b", c, tr_sig[c]);
            end
            n_checks++;
            if (tr_busy[c] !== (c >= 1 && c <= C + 2)) begin
                n_fail++; $display("FAIL simple_busy c=%0d: got %b", c, tr_busy[c]);
            end
            n_checks++;
            if (tr_done[c] !== (c == C + 2)) begin
                n_fail++; $display("FAIL simple_done c=%0d: got %b want %b", c, tr_done[c], (c == C + 2));
            end
            if (tr_done[c] === 1'b1) ndone++;
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL simple_done_count: got %0d want 1", ndone); end
        read_reg(TB_MFHI, v);
        n_checks++; if (v !== exp_hi) begin n_fail++; $display("FAIL simple_mfhi: got %h want %h", v, exp_hi); end
        read_reg(TB_MFLO, v);
        n_checks++; if (v !== exp_lo) begin n_fail++; $display("FAIL simple_mflo: got %h want %h", v, exp_lo); end
        n_checks++; if (v !== 32'd15) begin n_fail++; $display("FAIL simple_mflo_const: got %h want 0000000f", v); end
        // dataOut holds between reads
        tick(); tick();
        n_checks++; if (dataOut !== exp_lo) begin n_fail++; $display("FAIL simple_hold: got %h want %h", dataOut, exp_lo); end
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] v;
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = TB_MULTU;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        Signal = 6'd0;
        for (int c = 1; c < 10; c++) tick();
        n_checks++; if (mulSignal !== TB_MULTU) begin n_fail++; $display("FAIL midrun_pre_sig: got %b want %b", mulSignal, TB_MULTU); end
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrun_done: got %b want 0", done); end
        n_checks++; if (mulLoad !== 1'b0) begin n_fail++; $display("FAIL midrun_mulLoad: got %b want 0", mulLoad); end
        n_checks++; if (mulSignal !== TB_OUT) begin n_fail++; $display("FAIL midrun_mulSignal: got %b want %b", mulSignal, TB_OUT); end
        n_checks++; if (dataOut !== '0) begin n_fail++; $display("FAIL midrun_dataOut: got %h want 0", dataOut); end
        tick(); tick();
        reset  = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        tick();
        for (int c = 0; c < C + 4; c++) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_resume c=%0d: busy=%b want 0", c, busy); end
            tick();
        end
        read_reg(TB_MFLO, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_mflo: got %h want 0", v); end
        read_reg(TB_MFHI, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_mfhi: got %h want 0", v); end
    endtask

    task automatic test_full_range;
        logic [W-1:0] v;
        run_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6'd0);
        read_reg(TB_MFHI, v);
        n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL full_mfhi: got %h want fffffffe", v); end
        read_reg(TB_MFLO, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL full_mflo: got %h want 00000001", v); end
    endtask

    task automatic test_edge_cases;
        logic [W-1:0] v;
        logic [W-1:0] d0;
        run_multu(32'h8000_0000, 32'd2, 0, 6'd0);
        read_reg(TB_MFHI, v);
        n_checks++; if (v !== exp_hi) begin n_fail++; $display("FAIL edge_mfhi: got %h want %h", v, exp_hi); end
        read_reg(TB_MFLO, v);
        n_checks++; if (v !== exp_lo) begin n_fail++; $display("FAIL edge_mflo: got %h want %h", v, exp_lo); end
        // unknown function code in IDLE
        d0     = dataOut;
        Signal = 6'b000000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unknown_busy c=%0d: got %b want 0", c, busy); end
            n_checks++; if (mulLoad !== 1'b0) begin n_fail++; $display("FAIL unknown_mulLoad c=%0d: got %b want 0", c, mulLoad); end
            n_checks++; if (dataOut !== d0) begin n_fail++; $display("FAIL unknown_dataOut c=%0d: got %h want %h", c, dataOut, d0); end
            tick();
        end
    endtask

    task automatic test_busy_window;
        logic [W-1:0] v;
        logic [W-1:0] d0;
        logic [W-1:0] hi1;
        logic [W-1:0] lo1;
        int ndone;
        logic [5:0] codes [3];
        int         cyc   [3];
        codes[0] = TB_MFHI;  cyc[0] = 5;
        codes[1] = TB_MULTU; cyc[1] = 20;
        codes[2] = TB_MULTU; cyc[2] = C + 2;
        for (int k = 0; k < 3; k++) begin
            read_reg(TB_MFLO, d0);
            run_multu(32'h0001_2345 + k, 32'h0BAD_F00D - k, cyc[k], codes[k]);
            hi1   = exp_hi;
            lo1   = exp_lo;
            ndone = 0;
            for (int c = 1; c <= C + 3; c++) begin
                n_checks++;
                if (tr_dout[c] !== d0) begin
                    n_fail++; $display("FAIL busywin_dataOut k=%0d c=%0d: got %h want %h", k, c, tr_dout[c], d0);
                end
                if (tr_done[c] === 1'b1) ndone++;
            end
            for (int c = 0; c < C + 4; c++) begin
                if (done === 1'b1) ndone++;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busywin_extra_busy k=%0d c=%0d", k, c); end
                tick();
            end
            n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL busywin_done_count k=%0d: got %0d want 1", k, ndone); end
            read_reg(TB_MFHI, v);
            n_checks++; if (v !== hi1) begin n_fail++; $display("FAIL busywin_mfhi k=%0d: got %h want %h", k, v, hi1); end
            read_reg(TB_MFLO, v);
            n_checks++; if (v !== lo1) begin n_fail++; $display("FAIL busywin_mflo k=%0d: got %h want %h", k, v, lo1); end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] v;
        logic [W-1:0] old_lo;
        run_multu(32'd1000, 32'd1000, 0, 6'd0);
        old_lo = exp_lo;
        run_multu(32'd12345, 32'd6789, 0, 6'd0);
        read_reg(TB_MFLO, v);
        n_checks++; if (v !== exp_lo) begin n_fail++; $display("FAIL b2b_mflo: got %h want %h (old %h)", v, exp_lo, old_lo); end
        run_multu(32'hDEAD_BEEF, 32'h1234_5678, 0, 6'd0);
        read_reg(TB_MFHI, v);
        n_checks++; if (v !== exp_hi) begin n_fail++; $display("FAIL b2b_mfhi: got %h want %h", v, exp_hi); end
    endtask

    task automatic test_random;
        logic [W-1:0] v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = $urandom;
            if (k == 0) a = '0;
            run_multu(a, b, int'($urandom_range(C + 2, 1)), ($urandom_range(1, 0) == 1) ? TB_MULTU : TB_MFLO);
            read_reg(TB_MFHI, v);
            n_checks++; if (v !== exp_hi) begin n_fail++; $display("FAIL rand_mfhi k=%0d a=%h b=%h: got %h want %h", k, a, b, v, exp_hi); end
            read_reg(TB_MFLO, v);
            n_checks++; if (v !== exp_lo) begin n_fail++; $display("FAIL rand_mflo k=%0d a=%h b=%h: got %h want %h", k, a, b, v, exp_lo); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simple_multiply();
        test_reset_mid_run();
        test_full_range();
        test_edge_cases();
        test_busy_window();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencer and result holder for the iterative unsigned multiplier. It decodes the multiply-group function code from the decode stage and drives the multiplier's operand-load and step controls for a fixed number of cycles. It then captures the 64-bit product into HI/LO registers and serves MFHI/MFLO reads. It sits between decode (upstream) and the shift-add multiplier (its `dataOut` feeds `mulProduct`).

## Interface
Parameters:
- `WIDTH`, 32: operand width; the product is `2*WIDTH`.
- `CYCLES`, 32: number of MULTU step cycles issued per multiply.

Ports:
- `clk`  in  1  the single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; `Signal` is valid while it is high.
- `Signal`  in  6  function code: MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010.
- `mulProduct`  in  2*WIDTH  product from the multiplier.
- `mulLoad`  out  1  active-high operand load to the multiplier (its reset/load input).
- `mulSignal`  out  6  step control to the multiplier: MULTU while stepping, OUT (6'b111111) otherwise.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when HI/LO are written.
- `dataOut`  out  WIDTH  registered HI or LO read result.

## Operation
- FSM states:
  - IDLE: `busy`=0, `mulSignal`=OUT.
  - LOAD: `mulLoad`=1 for exactly one cycle, `busy`=1.
  - RUN: `mulSignal`=MULTU, step counter runs 0..CYCLES-1, `busy`=1.
  - CAPTURE: `mulSignal`=OUT, `done`=1, `busy`=1.
- IDLE, `start`=1:
  - `Signal`=MULTU: go to LOAD.
  - MFHI: `dataOut`<=HI; stay IDLE.
  - MFLO: `dataOut`<=LO; stay IDLE.
  - Any other code: ignored, no state change.
- LOAD always goes to RUN, with the counter set to 0.
- RUN: the counter increments every cycle. When the counter equals CYCLES-1, go to CAPTURE.
- CAPTURE: on its edge, HI<=`mulProduct[2W-1:W]` and LO<=`mulProduct[W-1:0]`, then go to IDLE.
- `start` is ignored in LOAD, RUN and CAPTURE. No queueing; the requester must wait for `busy`=0.
- `mulLoad` and `mulSignal` are registered outputs. Both are glitch-free and decoded from the state.
- Unsigned only. HI/LO are never partially updated; both are written on the same edge.
- Reset (asserted at any time, including mid-RUN):
  - State returns to IDLE and the counter to 0.
  - HI=LO=0, `dataOut`=0, `busy`=0, `done`=0, `mulLoad`=0, `mulSignal`=OUT.
  - A multiply in flight is abandoned and HI/LO are not written.

## Timing
- The `start` edge is cycle 0. For MULTU:
  - LOAD is cycle 1.
  - RUN covers cycles 2..CYCLES+1.
  - CAPTURE is cycle CYCLES+2; `done` is high during it.
  - IDLE resumes at cycle CYCLES+3.
  - With the default, that is 35 cycles from the `start` edge until a new request is accepted.
- `busy` is high for cycles 1..CYCLES+2 inclusive.
- The multiplier product is final after the CYCLES-th MULTU edge. `mulSignal`=OUT holds it stable while CAPTURE samples it.
- MFHI/MFLO have one-cycle latency: `dataOut` is valid the cycle after the accepted `start`. It holds its value until the next accepted read or a reset.
- Back-to-back: a read issued in the first IDLE cycle after `done` returns the new result.
- Release of `reset` (deassertion) takes effect at the next `clk` edge.

## Structure
- Shared package `mul_pkg`:
  - function-code constants MULTU, MFHI, MFLO, OUT;
  - FSM state enum (IDLE, LOAD, RUN, CAPTURE);
  - default WIDTH/CYCLES.
- One sub-module is natural: `mul_step_counter`. It is a `$clog2(CYCLES)`-bit counter with clear, enable and a terminal-count output, used by the RUN state.
- The HI/LO/`dataOut` registers and the FSM remain in the top module.

## Test plan
The bench instantiates this block together with the existing multiplier; `dataA`/`dataB` are driven directly.
- Reset checks:
  - Assert reset mid-RUN (cycle 10) -> all outputs return to their reset values immediately, `mulSignal`=6'b111111.
  - A following MFLO then reads 0.
- Simple multiply:
  - A=3, B=5, start MULTU -> `mulLoad` high in cycle 1 only; 32 MULTU cycles; `done` at cycle 34.
  - Then MFLO -> `dataOut`=15; MFHI -> 0.
- Full-range multiply: A=B=0xFFFFFFFF -> MFHI=0xFFFFFFFE, MFLO=0x00000001.
- Busy-window requests:
  - Pulse start with MFHI, and separately MULTU, during `busy` -> ignored.
  - `dataOut` is unchanged, exactly one `done` pulse occurs, and the HI/LO values are from the first multiply.
- Edge cases:
  - Unknown code 6'b000000 in IDLE -> no state change, `busy` stays 0.
  - A=0x80000000, B=2 -> MFHI=1, MFLO=0.
- Back-to-back: MFLO in the first IDLE cycle after `done` -> returns the new LO, not the previous one.
